// File: rtl/fetch_bram_w_b_i_top.sv
// Shared weight/bias/input buffer: a 32-bit write port feeds a wide read port.
// Ports: clk/rst_n; start_fetch, reset_addr_counter, Buffer_Select,
// Tiles_Control, Double_buffering in; wea/ena/addra/dina write port in;
// fetch_done, doutb, addrb, busy out.
module fetch_bram_w_b_i_top #(
    parameter int ADDR_WIDTH       = 16,
    parameter int ORIGINAL_COLUMNS = 768,
    parameter int ORIGINAL_ROWS    = 512,
    parameter int NUM_BITS         = 8,
    parameter int DATA_WIDTH       = 256,
    parameter int WEIGHT_BASE      = 0,
    parameter int BIAS_BASE        = 1024,
    parameter int INPUT_BASE       = 0,
    parameter int DB_OFFSET        = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_fetch,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Buffer_Select,
    input  logic                  Tiles_Control,
    input  logic                  Double_buffering,
    input  logic                  wea,
    input  logic                  ena,
    input  logic [13:0]           addra,
    input  logic [31:0]           dina,
    output logic                  fetch_done,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic [ADDR_WIDTH-1:0] addrb,
    output logic                  busy
);

    localparam int DEPTH = 2048;
    localparam int RAW   = $clog2(DEPTH);
    localparam int SMALL = DATA_WIDTH / NUM_BITS;
    localparam int WRAP  = ORIGINAL_COLUMNS * ORIGINAL_ROWS / SMALL;
    localparam int CW    = $clog2(WRAP);
    localparam int LW    = $clog2(ORIGINAL_ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
    logic                  rd_q, rd_d;
    logic [DATA_WIDTH-1:0] doutb_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  sel_ok;
    logic [ADDR_WIDTH-1:0] sel_base;

    always_comb begin
        sel_ok   = 1'b1;
        sel_base = '0;
        case (Buffer_Select)
            3'b000:  sel_base = ADDR_WIDTH'(WEIGHT_BASE);
            3'b001:  sel_base = ADDR_WIDTH'(BIAS_BASE);
            3'b010:  sel_base = ADDR_WIDTH'(INPUT_BASE);
            default: sel_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addrb_d = addrb_q;
        rd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reset_addr_counter) begin
                    cnt_d = '0;
                end
                if (start_fetch && sel_ok) begin
                    state_d = S_FETCH;
                    base_d  = sel_base +
                              (Double_buffering ? ADDR_WIDTH'(DB_OFFSET) : '0);
                    len_d   = Tiles_Control ? LW'(SMALL) : LW'(ORIGINAL_ROWS);
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                // One wide read per cycle; the tile counter persists
                // across fetches so the next start walks on.
                addrb_d = base_q + ADDR_WIDTH'(cnt_q);
                rd_d    = 1'b1;
                cnt_d   = (cnt_q == CW'(WRAP - 1)) ? '0 : cnt_q + CW'(1);
                idx_d   = idx_q + LW'(1);
                if (idx_q == len_q - LW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            addrb_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addrb_q <= addrb_d;
            rd_q    <= rd_d;
        end
    end

    // Write-port lane select; contents survive reset.
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem_q[addra[13:3]][{addra[2:0], 5'b0} +: 32] <= dina;
        end
    end

    // Registered read; a same-cycle write to this word is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb_q <= '0;
        end else if (rd_q) begin
            doutb_q <= mem_q[addrb_q[RAW-1:0]];
        end
    end

    assign doutb      = doutb_q;
    assign addrb      = addrb_q;
    assign busy       = (state_q != S_IDLE);
    assign fetch_done = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_bram_w_b_i_top.sv
// Randomized scoreboard bench for fetch_bram_w_b_i_top.
// Stimulus pushes expected addresses/words; a negedge monitor checks them.
module tb_fetch_bram_w_b_i_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_fetch = 1'b0;
    logic         reset_addr_counter = 1'b0;
    logic [2:0]   Buffer_Select = 3'b000;
    logic         Tiles_Control = 1'b0;
    logic         Double_buffering = 1'b0;
    logic         wea = 1'b0;
    logic         ena = 1'b0;
    logic [13:0]  addra = '0;
    logic [31:0]  dina = '0;
    logic         fetch_done;
    logic [255:0] doutb;
    logic [15:0]  addrb;
    logic         busy;

    always #5 clk = ~clk;

    fetch_bram_w_b_i_top dut (
        .clk(clk), .rst_n(rst_n), .start_fetch(start_fetch),
        .reset_addr_counter(reset_addr_counter),
        .Buffer_Select(Buffer_Select), .Tiles_Control(Tiles_Control),
        .Double_buffering(Double_buffering), .wea(wea), .ena(ena),
        .addra(addra), .dina(dina), .fetch_done(fetch_done),
        .doutb(doutb), .addrb(addrb), .busy(busy)
    );

    int unsigned  mdl [16384];
    int           mcnt = 0;
    int           checks = 0;
    int           failures = 0;
    logic [15:0]  qa [$];
    logic [255:0] qd [$];
    int           qn [$];
    bit           active = 0;
    int           mc = 0;
    int           mn = 0;

    function automatic logic [255:0] wide(int w);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = mdl[8*w + j];
        return r;
    endfunction

    task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, e);
        end
    endtask

    // Monitor: times every response relative to the first busy cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
                qa.delete(); qd.delete(); qn.delete();
            end else if (active) begin
                mc++;
                if (mc <= mn) begin
                    if (qa.size() == 0) chk("addr_underflow", 1, 0);
                    else chk("addrb", {240'b0, addrb}, {240'b0, qa.pop_front()});
                end
                if (mc >= 2 && mc <= mn + 1) begin
                    if (qd.size() == 0) chk("data_underflow", 1, 0);
                    else chk("doutb", doutb, qd.pop_front());
                end
                chk("fetch_done", {255'b0, fetch_done}, {255'b0, mc == mn + 1});
                if (mc <= mn + 1) chk("busy_hi", {255'b0, busy}, 1);
                if (mc == mn + 2) begin
                    chk("busy_end", {255'b0, busy}, 0);
                    active = 0;
                end
            end else if (busy) begin
                active = 1;
                mc = 0;
                if (qn.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                    mn = 0;
                end else begin
                    mn = qn.pop_front();
                end
                chk("done_early", {255'b0, fetch_done}, 0);
            end else begin
                chk("done_idle", {255'b0, fetch_done}, 0);
            end
        end
    end

    task automatic clr();
        @(negedge clk);
        reset_addr_counter = 1'b1;
        @(negedge clk);
        reset_addr_counter = 1'b0;
        mcnt = 0;
    endtask

    task automatic fetch(logic [2:0] sel, bit tc, bit db);
        int n;
        int base;
        int a;
        @(negedge clk);
        Buffer_Select = sel;
        Tiles_Control = tc;
        Double_buffering = db;
        start_fetch = 1'b1;
        if (sel <= 3'd2) begin
            n = tc ? 32 : 512;
            base = (sel == 3'd1) ? 1024 : 0;
            if (db) base += 512;
            for (int i = 0; i < n; i++) begin
                a = base + mcnt;
                qa.push_back(a[15:0]);
                qd.push_back(wide(a % 2048));
                mcnt = (mcnt + 1) % 12288;
            end
            qn.push_back(n);
        end
        @(negedge clk);
        start_fetch = 1'b0;
    endtask

    task automatic wait_idle(int bound);
        int t = 0;
        while ((busy || active || qn.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {255'b0, t >= bound}, 0);
    endtask

    task automatic wr(int a, int unsigned d);
        @(negedge clk);
        ena = 1'b1; wea = 1'b1;
        addra = a[13:0]; dina = d;
        mdl[a] = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        ena = 1'b0; wea = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        chk("rst_busy", {255'b0, busy}, 0);
        chk("rst_addrb", {240'b0, addrb}, 0);
        chk("rst_doutb", doutb, 0);
        chk("rst_done", {255'b0, fetch_done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16384; i++) wr(i, 2*i + 2);
        wr_end();

        clr();
        fetch(3'b000, 1, 0);
        wait_idle(60);
        chk("w32_last_lane7", {224'b0, doutb[255:224]}, 512);
        chk("w32_hold_addr", {240'b0, addrb}, 31);

        clr();
        fetch(3'b010, 0, 0);
        wait_idle(540);
        chk("in512_last_lane7", {224'b0, doutb[255:224]}, 8192);

        clr();
        fetch(3'b000, 1, 0);
        wait_idle(60);
        fetch(3'b000, 1, 0);
        wait_idle(60);
        chk("cont_last_lane7", {224'b0, doutb[255:224]}, 1024);
        chk("cont_last_addr", {240'b0, addrb}, 63);

        clr();
        fetch(3'b000, 1, 1);
        wait_idle(60);
        chk("db_w32_lane7", {224'b0, doutb[255:224]}, 8704);
        clr();
        fetch(3'b010, 0, 1);
        wait_idle(540);
        chk("db_in512_addr", {240'b0, addrb}, 1023);

        clr();
        fetch(3'b001, 1, 0);
        wait_idle(60);
        chk("bias_addr", {240'b0, addrb}, 1055);

        // Start pulse during a fetch must not restart or resize it.
        clr();
        fetch(3'b010, 0, 0);
        repeat (10) @(negedge clk);
        Tiles_Control = 1'b1;
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        wait_idle(540);

        fetch(3'b111, 1, 0);
        repeat (4) @(negedge clk);
        chk("bad_sel_busy", {255'b0, busy}, 0);
        chk("bad_sel_addr", {240'b0, addrb}, 511);

        fetch(3'b010, 0, 0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {255'b0, busy}, 0);
        chk("midrst_addrb", {240'b0, addrb}, 0);
        chk("midrst_done", {255'b0, fetch_done}, 0);
        chk("midrst_doutb", doutb, 0);
        mcnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fetch(3'b000, 1, 0);
        wait_idle(60);
        chk("post_rst_addr", {240'b0, addrb}, 31);

        for (int it = 0; it < 25; it++) begin
            int nw = $urandom_range(0, 6);
            for (int k = 0; k < nw; k++) wr($urandom_range(0, 16383), $urandom);
            wr_end();
            if ($urandom_range(0, 3) == 0) clr();
            fetch(3'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
            wait_idle(540);
        end

        // Walk the counter through its full range to hit the wrap.
        clr();
        for (int t = 0; t < 24; t++) begin
            fetch(3'b010, 0, 0);
            wait_idle(540);
        end
        fetch(3'b000, 1, 0);
        wait_idle(60);
        chk("wrap_addr", {240'b0, addrb}, 31);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
